// File: rtl/core_if_id.sv
// IF->ID pipeline register as a small elastic FIFO: holds fetched {inst, addr}
// pairs while decode stalls, drops everything on redirect, and shows a NOP bubble when empty.
module core_if_id #(
  parameter int                    INST_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [INST_WIDTH-1:0] NOP_INST   = 32'h00000013,
  parameter int                    DEPTH      = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       if_valid_in,
  output logic                       if_ready_out,
  input  logic [INST_WIDTH-1:0]      inst_in,
  input  logic [ADDR_WIDTH-1:0]      inst_addr_in,
  input  logic                       flush_in,
  input  logic                       id_ready_in,
  output logic                       inst_valid_out,
  output logic [INST_WIDTH-1:0]      inst_out,
  output logic [ADDR_WIDTH-1:0]      inst_addr_out,
  output logic [$clog2(DEPTH):0]     count_out
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [INST_WIDTH-1:0] inst_mem_q [DEPTH];
  logic [INST_WIDTH-1:0] inst_mem_d [DEPTH];
  logic [ADDR_WIDTH-1:0] addr_mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] addr_mem_d [DEPTH];
  logic                  push;
  logic                  pop;

  // Handshake: a beat transfers on a side only in a cycle where both valid and
  // ready are high at the rising edge; ready never depends on the other side's
  // valid/ready, so there is no combinational path from id_ready_in to if_ready_out.
  assign if_ready_out   = (count_q != FULL_CNT);
  assign inst_valid_out = (count_q != '0);
  assign inst_out       = inst_valid_out ? inst_mem_q[rd_ptr_q] : NOP_INST;
  assign inst_addr_out  = inst_valid_out ? addr_mem_q[rd_ptr_q] : '0;
  assign count_out      = count_q;

  always_comb begin
    push       = if_valid_in & if_ready_out & ~flush_in;
    pop        = inst_valid_out & id_ready_in & ~flush_in;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    inst_mem_d = inst_mem_q;
    addr_mem_d = addr_mem_q;
    if (flush_in) begin
      // Redirect: every held entry and any incoming fetch is stale.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        inst_mem_d[wr_ptr_q] = inst_in;
        addr_mem_d[wr_ptr_q] = inst_addr_in;
        wr_ptr_d             = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: it is only ever read while count_q says it is valid.
  always_ff @(posedge clk) begin
    inst_mem_q <= inst_mem_d;
    addr_mem_q <= addr_mem_d;
  end

endmodule

// File: tb/tb_core_if_id.sv
// Directed bench for core_if_id: reset, streaming, back-pressure, flush,
// pointer wrap under simultaneous push/pop, and reset in the middle of traffic.
module tb_core_if_id;

  logic        clk;
  logic        rst;
  logic        if_valid_in;
  logic        if_ready_out;
  logic [31:0] inst_in;
  logic [31:0] inst_addr_in;
  logic        flush_in;
  logic        id_ready_in;
  logic        inst_valid_out;
  logic [31:0] inst_out;
  logic [31:0] inst_addr_out;
  logic [1:0]  count_out;

  int tests_run;
  int tests_failed;

  logic [63:0] exp_q [$];
  logic [63:0] exp_item;

  core_if_id dut (
    .clk            (clk),
    .rst            (rst),
    .if_valid_in    (if_valid_in),
    .if_ready_out   (if_ready_out),
    .inst_in        (inst_in),
    .inst_addr_in   (inst_addr_in),
    .flush_in       (flush_in),
    .id_ready_in    (id_ready_in),
    .inst_valid_out (inst_valid_out),
    .inst_out       (inst_out),
    .inst_addr_out  (inst_addr_out),
    .count_out      (count_out)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // Driver tasks: inputs change 1ns after the rising edge, checks follow 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] i, input logic [31:0] a,
                       input logic r, input logic f);
    if_valid_in  = v;
    inst_in      = i;
    inst_addr_in = a;
    id_ready_in  = r;
    flush_in     = f;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    tests_run++;
    if (if_ready_out !== 1'b1) begin
      tests_failed++; $display("FAIL reset_ready got=%b exp=1", if_ready_out);
    end
    tests_run++;
    if (inst_valid_out !== 1'b0) begin
      tests_failed++; $display("FAIL reset_valid got=%b exp=0", inst_valid_out);
    end
    tests_run++;
    if (inst_out !== 32'h00000013) begin
      tests_failed++; $display("FAIL reset_inst got=%h exp=00000013", inst_out);
    end
    tests_run++;
    if (inst_addr_out !== 32'h0) begin
      tests_failed++; $display("FAIL reset_addr got=%h exp=00000000", inst_addr_out);
    end
    tests_run++;
    if (count_out !== 2'd0) begin
      tests_failed++; $display("FAIL reset_count got=%0d exp=0", count_out);
    end
  endtask

  task automatic test_stream();
    drive(1'b1, 32'h00500093, 32'h0, 1'b1, 1'b0);
    tests_run++;
    if (inst_valid_out !== 1'b0 || inst_out !== 32'h00000013) begin
      tests_failed++;
      $display("FAIL stream_no_bypass got=valid %b inst %h exp=valid 0 inst 00000013",
               inst_valid_out, inst_out);
    end
    tick();
    drive(1'b1, 32'h00A00113, 32'h4, 1'b1, 1'b0);
    tests_run++;
    if (inst_valid_out !== 1'b1 || inst_out !== 32'h00500093 || inst_addr_out !== 32'h0
        || count_out !== 2'd1) begin
      tests_failed++;
      $display("FAIL stream_first got=v%b %h@%h cnt%0d exp=v1 00500093@00000000 cnt1",
               inst_valid_out, inst_out, inst_addr_out, count_out);
    end
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    tests_run++;
    if (inst_valid_out !== 1'b1 || inst_out !== 32'h00A00113 || inst_addr_out !== 32'h4
        || count_out !== 2'd1) begin
      tests_failed++;
      $display("FAIL stream_second got=v%b %h@%h cnt%0d exp=v1 00a00113@00000004 cnt1",
               inst_valid_out, inst_out, inst_addr_out, count_out);
    end
    tick();
    tests_run++;
    if (inst_valid_out !== 1'b0 || count_out !== 2'd0 || inst_out !== 32'h00000013) begin
      tests_failed++;
      $display("FAIL stream_drain got=v%b cnt%0d inst %h exp=v0 cnt0 inst 00000013",
               inst_valid_out, count_out, inst_out);
    end
  endtask

  task automatic test_backpressure();
    exp_q.delete();
    drive(1'b1, 32'h00100193, 32'h8, 1'b0, 1'b0);
    exp_q.push_back({32'h00100193, 32'h8});
    tick();
    drive(1'b1, 32'h00200213, 32'hC, 1'b0, 1'b0);
    exp_q.push_back({32'h00200213, 32'hC});
    tick();
    drive(1'b1, 32'h00300293, 32'h10, 1'b0, 1'b0);
    tests_run++;
    if (count_out !== 2'd2 || if_ready_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_full got=cnt%0d rdy%b exp=cnt2 rdy0", count_out, if_ready_out);
    end
    tick();
    tests_run++;
    if (count_out !== 2'd2) begin
      tests_failed++; $display("FAIL bp_hold_c got=cnt%0d exp=cnt2", count_out);
    end
    // Release decode while C is still offered: full, so C is not taken this cycle.
    drive(1'b1, 32'h00300293, 32'h10, 1'b1, 1'b0);
    tests_run++;
    if (if_ready_out !== 1'b0) begin
      tests_failed++; $display("FAIL bp_ready_indep got=rdy%b exp=rdy0", if_ready_out);
    end
    exp_q.push_back({32'h00300293, 32'h10});
    for (int c = 0; c < 3; c++) begin
      exp_item = exp_q.pop_front();
      tests_run++;
      if (inst_valid_out !== 1'b1 || {inst_out, inst_addr_out} !== exp_item) begin
        tests_failed++;
        $display("FAIL bp_order%0d got=v%b %h@%h exp=v1 %h@%h", c, inst_valid_out,
                 inst_out, inst_addr_out, exp_item[63:32], exp_item[31:0]);
      end
      tick();
      if (c == 0) begin
        tests_run++;
        if (count_out !== 2'd1 || if_ready_out !== 1'b1) begin
          tests_failed++;
          $display("FAIL bp_no_push_when_full got=cnt%0d rdy%b exp=cnt1 rdy1",
                   count_out, if_ready_out);
        end
      end else begin
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      end
    end
    tests_run++;
    if (count_out !== 2'd0 || inst_valid_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_drain got=cnt%0d v%b exp=cnt0 v0", count_out, inst_valid_out);
    end
  endtask

  task automatic test_flush();
    drive(1'b1, 32'h11111111, 32'h100, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h22222222, 32'h104, 1'b0, 1'b0);
    tick();
    tests_run++;
    if (count_out !== 2'd2) begin
      tests_failed++; $display("FAIL flush_prefill got=cnt%0d exp=cnt2", count_out);
    end
    drive(1'b1, 32'hDDDDDDDD, 32'h14, 1'b1, 1'b1);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    tests_run++;
    if (count_out !== 2'd0 || inst_valid_out !== 1'b0 || inst_out !== 32'h00000013
        || inst_addr_out !== 32'h0 || if_ready_out !== 1'b1) begin
      tests_failed++;
      $display("FAIL flush_empty got=cnt%0d v%b %h@%h rdy%b exp=cnt0 v0 00000013@00000000 rdy1",
               count_out, inst_valid_out, inst_out, inst_addr_out, if_ready_out);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      tests_run++;
      if (inst_valid_out !== 1'b0) begin
        tests_failed++;
        $display("FAIL flush_d_leak%0d got=v%b %h@%h exp=v0", c, inst_valid_out,
                 inst_out, inst_addr_out);
      end
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 32'h10000000, 32'h20, 1'b1, 1'b0);
    tick();
    for (int i = 1; i <= 6; i++) begin
      drive(1'b1, 32'h10000000 + i, 32'h20 + 4 * i, 1'b1, 1'b0);
      tests_run++;
      if (count_out !== 2'd1 || inst_addr_out !== 32'h20 + 4 * (i - 1)
          || inst_out !== 32'h10000000 + (i - 1)) begin
        tests_failed++;
        $display("FAIL b2b_step%0d got=cnt%0d %h@%h exp=cnt1 %h@%h", i, count_out,
                 inst_out, inst_addr_out, 32'h10000000 + (i - 1), 32'h20 + 4 * (i - 1));
      end
      tick();
    end
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    tests_run++;
    if (count_out !== 2'd1 || inst_addr_out !== 32'h38 || inst_out !== 32'h10000006) begin
      tests_failed++;
      $display("FAIL b2b_last got=cnt%0d %h@%h exp=cnt1 10000006@00000038",
               count_out, inst_out, inst_addr_out);
    end
    tick();
    tests_run++;
    if (count_out !== 2'd0) begin
      tests_failed++; $display("FAIL b2b_drain got=cnt%0d exp=cnt0", count_out);
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 32'h33333333, 32'h200, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h44444444, 32'h204, 1'b0, 1'b0);
    tick();
    tests_run++;
    if (count_out !== 2'd2) begin
      tests_failed++; $display("FAIL rstmid_prefill got=cnt%0d exp=cnt2", count_out);
    end
    rst = 1'b1;
    drive(1'b1, 32'h55555555, 32'h3C, 1'b1, 1'b0);
    tick();
    rst = 1'b0;
    drive(1'b1, 32'h0EEE0EEE, 32'h40, 1'b0, 1'b0);
    tests_run++;
    if (count_out !== 2'd0 || inst_valid_out !== 1'b0 || if_ready_out !== 1'b1) begin
      tests_failed++;
      $display("FAIL rstmid_cleared got=cnt%0d v%b rdy%b exp=cnt0 v0 rdy1",
               count_out, inst_valid_out, if_ready_out);
    end
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    tests_run++;
    if (count_out !== 2'd1 || inst_out !== 32'h0EEE0EEE || inst_addr_out !== 32'h40) begin
      tests_failed++;
      $display("FAIL rstmid_first_e got=cnt%0d %h@%h exp=cnt1 0eee0eee@00000040",
               count_out, inst_out, inst_addr_out);
    end
    tick();
    tests_run++;
    if (count_out !== 2'd0 || inst_valid_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL rstmid_drain got=cnt%0d v%b exp=cnt0 v0", count_out, inst_valid_out);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b1;
    if_valid_in  = 1'b0;
    inst_in      = 32'h0;
    inst_addr_in = 32'h0;
    flush_in     = 1'b0;
    id_ready_in  = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
